vend_sequencer: RTL

- Credit and sequencing controller for the vending datapath.
- Accumulates coin credit by denomination and checks a selection against a per-product price.
- Drives the product dispenser through a req/ack handshake, then pays out change one coin at a time (largest coin first).
- Sits between the coin acceptor, the button panel, the dispenser and the coin hopper.

---
 rtl/vend_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit accumulation, price check, dispenser req/ack
// handshake and largest-coin-first change payout.
module vend_sequencer #(
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 100,
  parameter int PRICE_0      = 5,
  parameter int PRICE_1      = 7,
  parameter int PRICE_2      = 10,
  parameter int PRICE_3      = 12,
  parameter int DISP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_prod,
  input  logic                return_btn,
  input  logic                disp_ack,
  input  logic                change_ready,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                short_credit,
  output logic                disp_req,
  output logic [1:0]          disp_prod,
  output logic                change_valid,
  output logic [1:0]          change_type,
  output logic                fault,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);

  localparam logic [CREDIT_W-1:0] CR_ZERO  = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] VAL_1    = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] VAL_5    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL_10   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] VAL_50   = CREDIT_W'(50);
  localparam logic [SUM_W-1:0]    MAX_SUM  = SUM_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DISP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  // Value in credit units of a coin code (shared by acceptor and hopper).
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd0:    coin_value = VAL_1;
      2'd1:    coin_value = VAL_5;
      2'd2:    coin_value = VAL_10;
      2'd3:    coin_value = VAL_50;
      default: coin_value = VAL_1;
    endcase
  endfunction

  // Price table lookup.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] prod);
    case (prod)
      2'd0:    price_of = CREDIT_W'(PRICE_0);
      2'd1:    price_of = CREDIT_W'(PRICE_1);
      2'd2:    price_of = CREDIT_W'(PRICE_2);
      2'd3:    price_of = CREDIT_W'(PRICE_3);
      default: price_of = CREDIT_W'(PRICE_3);
    endcase
  endfunction

  // Largest coin not exceeding the given amount (1 is used for amount 0).
  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= VAL_50) begin
      largest_coin = 2'd3;
    end else if (amt >= VAL_10) begin
      largest_coin = 2'd2;
    end else if (amt >= VAL_5) begin
      largest_coin = 2'd1;
    end else begin
      largest_coin = 2'd0;
    end
  endfunction

  state_t              state_r, state_s;
  logic [CREDIT_W-1:0] credit_r, credit_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [1:0]          disp_prod_r, disp_prod_s;
  logic [1:0]          change_type_r, change_type_s;
  logic                disp_req_r, disp_req_s;
  logic                change_valid_r, change_valid_s;
  logic                coin_accept_r, coin_accept_s;
  logic                coin_reject_r, coin_reject_s;
  logic                short_credit_r, short_credit_s;
  logic                fault_r, fault_s;
  logic                busy_r, busy_s;
  logic [CREDIT_W-1:0] coin_val_s, sel_price_s, base_s;
  logic [SUM_W-1:0]    sum_s;

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_s        = state_r;
    credit_s       = credit_r;
    cnt_s          = cnt_r;
    disp_prod_s    = disp_prod_r;
    change_type_s  = change_type_r;
    disp_req_s     = disp_req_r;
    change_valid_s = change_valid_r;
    coin_accept_s  = 1'b0;
    coin_reject_s  = 1'b0;
    short_credit_s = 1'b0;
    fault_s        = 1'b0;
    coin_val_s     = coin_value(coin_type);
    sel_price_s    = price_of(sel_prod);
    base_s         = credit_r;
    sum_s          = {SUM_W{1'b0}};

    case (state_r)
      ST_IDLE: begin
        short_credit_s = sel_valid;
        if (coin_valid) begin
          credit_s      = coin_val_s;
          coin_accept_s = 1'b1;
          state_s       = ST_CREDIT;
        end else begin
          credit_s = credit_r;
        end
      end

      ST_CREDIT: begin
        if (return_btn) begin
          coin_reject_s = coin_valid;
          if (credit_r != CR_ZERO) begin
            state_s        = ST_CHANGE;
            change_valid_s = 1'b1;
            change_type_s  = largest_coin(credit_r);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          // Price check sees the credit before any coin arriving this cycle.
          if (sel_valid && (credit_r >= sel_price_s)) begin
            base_s      = credit_r - sel_price_s;
            disp_prod_s = sel_prod;
            disp_req_s  = 1'b1;
            cnt_s       = CNT_ZERO;
            state_s     = ST_DISPENSE;
          end else begin
            base_s         = credit_r;
            short_credit_s = sel_valid;
          end
          // Coin limit check sees the credit after any deduction.
          sum_s = {1'b0, base_s} + {1'b0, coin_val_s};
          if (coin_valid && (sum_s <= MAX_SUM)) begin
            credit_s      = sum_s[CREDIT_W-1:0];
            coin_accept_s = 1'b1;
          end else begin
            credit_s      = base_s;
            coin_reject_s = coin_valid;
          end
        end
      end

      ST_DISPENSE: begin
        coin_reject_s = coin_valid;
        if (disp_ack) begin
          disp_req_s = 1'b0;
          cnt_s      = CNT_ZERO;
          if (credit_r != CR_ZERO) begin
            state_s        = ST_CHANGE;
            change_valid_s = 1'b1;
            change_type_s  = largest_coin(credit_r);
          end else begin
            state_s = ST_IDLE;
          end
        end else if (cnt_r == CNT_LAST) begin
          // Dispenser never answered: give the price back and pay it out.
          fault_s        = 1'b1;
          disp_req_s     = 1'b0;
          cnt_s          = CNT_ZERO;
          credit_s       = credit_r + price_of(disp_prod_r);
          change_valid_s = 1'b1;
          change_type_s  = largest_coin(credit_s);
          state_s        = ST_CHANGE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_CHANGE: begin
        coin_reject_s = coin_valid;
        if (change_ready) begin
          credit_s      = credit_r - coin_value(change_type_r);
          change_type_s = largest_coin(credit_s);
          if (credit_s == CR_ZERO) begin
            change_valid_s = 1'b0;
            state_s        = ST_IDLE;
          end else begin
            change_valid_s = 1'b1;
          end
        end else begin
          credit_s = credit_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_DISPENSE) || (state_s == ST_CHANGE);
  end

  // State and output registers; reset drops credit and any handshake at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      credit_r       <= CR_ZERO;
      cnt_r          <= CNT_ZERO;
      disp_prod_r    <= 2'd0;
      change_type_r  <= 2'd0;
      disp_req_r     <= 1'b0;
      change_valid_r <= 1'b0;
      coin_accept_r  <= 1'b0;
      coin_reject_r  <= 1'b0;
      short_credit_r <= 1'b0;
      fault_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      credit_r       <= credit_s;
      cnt_r          <= cnt_s;
      disp_prod_r    <= disp_prod_s;
      change_type_r  <= change_type_s;
      disp_req_r     <= disp_req_s;
      change_valid_r <= change_valid_s;
      coin_accept_r  <= coin_accept_s;
      coin_reject_r  <= coin_reject_s;
      short_credit_r <= short_credit_s;
      fault_r        <= fault_s;
      busy_r         <= busy_s;
    end
  end

  assign coin_accept  = coin_accept_r;
  assign coin_reject  = coin_reject_r;
  assign short_credit = short_credit_r;
  assign disp_req     = disp_req_r;
  assign disp_prod    = disp_prod_r;
  assign change_valid = change_valid_r;
  assign change_type  = change_type_r;
  assign fault        = fault_r;
  assign credit       = credit_r;
  assign busy         = busy_r;

endmodule
